// File: rtl/dht22_reader.sv
// DHT22 single-wire master: start pulse, response handshake, 40-bit capture,
// checksum verification and publication of the humidity:temperature word.
module dht22_reader #(
  parameter int CYCLES_PER_US = 50,
  parameter int START_LOW_US  = 1000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic        busy,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [1:0]  error_code
);

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(CYCLES_PER_US - 1);
  localparam logic [15:0]   START_LOW_C  = 16'(START_LOW_US);
  localparam logic [15:0]   BIT_THRESH_C = 16'(BIT_THRESH_US);
  localparam logic [15:0]   TIMEOUT_C    = 16'(TIMEOUT_US);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, line_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   us_cnt_q, us_cnt_d;
  logic [39:0]   shift_q, shift_d;
  logic [5:0]    bit_idx_q, bit_idx_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic [1:0]    err_q, err_d;

  logic          us_tick;
  logic [15:0]   us_elapsed;
  logic          line_rise, line_fall;
  logic          timed_out;
  logic [7:0]    byte_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      presc_q     <= '0;
      us_cnt_q    <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      sync1_q     <= dht_in;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      presc_q     <= presc_d;
      us_cnt_q    <= us_cnt_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // us_elapsed is the count as it stands at the end of this cycle, so phase
  // durations compare in whole microseconds without a one-tick lag.
  assign us_tick    = (presc_q == PRESC_LAST);
  assign us_elapsed = (us_tick && us_cnt_q != 16'hFFFF) ? us_cnt_q + 16'd1 : us_cnt_q;
  assign line_rise  = sync2_q & ~line_prev_q;
  assign line_fall  = ~sync2_q & line_prev_q;
  assign timed_out  = (us_elapsed > TIMEOUT_C);
  assign byte_sum   = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START_LOW;
          err_d   = ERR_NONE;
        end
      end
      START_LOW: begin
        if (us_elapsed >= START_LOW_C) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (timed_out) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end else if (line_fall) begin
          state_d = RESP_LOW;
        end
      end
      RESP_LOW: begin
        if (timed_out) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end else if (line_rise) begin
          state_d = RESP_HIGH;
        end
      end
      RESP_HIGH: begin
        if (timed_out) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end else if (line_fall) begin
          state_d   = BIT_LOW;
          bit_idx_d = '0;
          shift_d   = '0;
        end
      end
      BIT_LOW: begin
        if (timed_out) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end else if (line_rise) begin
          state_d = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        if (timed_out) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end else if (line_fall) begin
          shift_d   = {shift_q[38:0], (us_elapsed > BIT_THRESH_C)};
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = (bit_idx_q == 6'd39) ? CHECK : BIT_LOW;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (byte_sum == shift_q[7:0]) begin
          data_d  = shift_q[39:8];
          valid_d = 1'b1;
        end else begin
          err_d = ERR_CHECKSUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The prescaler restarts with us_cnt on every state change so each phase is
  // measured from its own start rather than from a free-running phase.
  always_comb begin
    presc_d  = us_tick ? '0 : presc_q + PW'(1);
    us_cnt_d = us_elapsed;
    if (state_d != state_q) begin
      presc_d  = '0;
      us_cnt_d = '0;
    end
  end

  assign dht_oe     = (state_q == START_LOW);
  assign busy       = (state_q != IDLE);
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign error_code = err_q;

endmodule

// File: tb/tb_dht22_reader.sv
// Bench for dht22_reader: a sensor model drives the open-drain line while a
// frame-level model predicts the published word and error code.
module tb_dht22_reader;

   localparam int CPU = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        dht_oe;
   logic        busy;
   logic [31:0] data_out;
   logic        data_valid;
   logic [1:0]  error_code;

   logic        sensorLow = 1'b0;
   logic        dhtLine;

   int          assertions = 0;
   int          failures = 0;
   logic        checking = 1'b0;
   logic        inFlight = 1'b0;
   logic        validPending = 1'b0;
   logic        abortSensor = 1'b0;
   logic [31:0] expData = 32'h0;
   logic [1:0]  expErr = 2'd0;
   int          dvCount = 0;
   int          oeCycles = 0;
   int          busyCycles = 0;
   int          bitsSent = 0;
   int          highUs[40];

   // Open-drain bus: either side pulling low wins, otherwise the pull-up holds it high.
   assign dhtLine = ~(dht_oe | sensorLow);

   always #5 clk = ~clk;

   dht22_reader #(
      .CYCLES_PER_US(4),
      .START_LOW_US(20),
      .BIT_THRESH_US(50),
      .TIMEOUT_US(200)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dht_in(dhtLine),
      .dht_oe(dht_oe),
      .busy(busy),
      .data_out(data_out),
      .data_valid(data_valid),
      .error_code(error_code)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      assertions++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
      end
   endtask

   // Every-cycle comparison against the frame-level model.
   always @(negedge clk) begin
      if (checking && !rst) begin
         if (busy) checkOutput("errClearWhileBusy", error_code, 32'd0);
         if (dht_oe) checkOutput("oeImpliesBusy", busy, 32'd1);
         if (data_valid) begin
            dvCount++;
            checkOutput("dvExpected", validPending, 32'd1);
            checkOutput("dvData", data_out, expData);
            validPending = 1'b0;
         end
         if (!busy && !inFlight) begin
            checkOutput("idleData", data_out, expData);
            checkOutput("idleErr", error_code, expErr);
         end
         if (dht_oe) oeCycles++;
         if (busy) busyCycles++;
      end
   end

   task automatic holdUs(input int us);
      for (int k = 0; k < us * CPU; k++) @(negedge clk);
   endtask

   // Sensor side: 80/80 us response, then 50 us low plus a data-dependent high per bit.
   task automatic sensorFrame(input logic silent, input int nbits);
      int t;
      bitsSent = 0;
      t = 0;
      while (!dht_oe && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!dht_oe) begin
         checkOutput("oeRiseTimeout", dht_oe, 32'd1);
         return;
      end
      t = 0;
      while (dht_oe && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (dht_oe) begin
         checkOutput("oeFallTimeout", dht_oe, 32'd0);
         return;
      end
      if (silent) return;
      holdUs(30);
      sensorLow = 1'b1;
      holdUs(80);
      sensorLow = 1'b0;
      holdUs(80);
      for (int i = 0; i < nbits && !abortSensor; i++) begin
         sensorLow = 1'b1;
         holdUs(50);
         sensorLow = 1'b0;
         holdUs(highUs[i]);
         bitsSent = i + 1;
      end
      if (!abortSensor) begin
         sensorLow = 1'b1;
         holdUs(50);
      end
      sensorLow = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] b4, input logic [7:0] b3, input logic [7:0] b2,
                                input logic [7:0] b1, input logic [7:0] b0, input logic silent,
                                input int nbits, input int zero50Idx, input int one51Idx,
                                input int midStartCycle, input int resetAtBit);
      logic [39:0] frame;
      logic [1:0]  predErr;
      int          t;
      frame = {b4, b3, b2, b1, b0};
      for (int i = 0; i < 40; i++) highUs[i] = frame[39 - i] ? 70 : 26;
      if (zero50Idx >= 0) highUs[zero50Idx] = 50;
      if (one51Idx >= 0) highUs[one51Idx] = 51;
      if (silent || nbits < 40) predErr = 2'd1;
      else if (8'(b4 + b3 + b2 + b1) == b0) predErr = 2'd0;
      else predErr = 2'd2;

      inFlight = 1'b1;
      abortSensor = 1'b0;
      oeCycles = 0;
      busyCycles = 0;
      dvCount = 0;
      if (resetAtBit == 0) begin
         expErr = predErr;
         if (predErr == 2'd0) begin
            expData = {b4, b3, b2, b1};
            validPending = 1'b1;
         end
      end

      fork
         sensorFrame(silent, nbits);
         begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         begin
            if (midStartCycle > 0) begin
               repeat (midStartCycle) @(negedge clk);
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
         end
         begin
            int w;
            if (resetAtBit > 0) begin
               w = 0;
               while (bitsSent < resetAtBit && w < 30000) begin
                  @(negedge clk);
                  w++;
               end
               repeat (20) @(negedge clk);
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
               abortSensor = 1'b1;
               expData = 32'h0;
               expErr = 2'd0;
               validPending = 1'b0;
               checkOutput("rstOe", dht_oe, 32'd0);
               checkOutput("rstBusy", busy, 32'd0);
               checkOutput("rstData", data_out, 32'd0);
               checkOutput("rstValid", data_valid, 32'd0);
               checkOutput("rstErr", error_code, 32'd0);
            end
         end
      join

      t = 0;
      while (busy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      checkOutput("busyFalls", busy, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("dvCount", dvCount, (predErr == 2'd0 && resetAtBit == 0) ? 32'd1 : 32'd0);
      inFlight = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checking = 1'b1;
      checkOutput("resetOe", dht_oe, 32'd0);
      checkOutput("resetBusy", busy, 32'd0);
      checkOutput("resetData", data_out, 32'd0);
      checkOutput("resetValid", data_valid, 32'd0);
      checkOutput("resetErr", error_code, 32'd0);

      $display("[TB] good frame");
      applyStimulus(8'h02, 8'h8C, 8'h01, 8'h5F, 8'hEE, 1'b0, 40, -1, -1, 0, 0);
      checkOutput("goodOeCycles", oeCycles, 32'd80);
      checkOutput("goodData", data_out, 32'h028C015F);
      checkOutput("goodErr", error_code, 32'd0);

      $display("[TB] bad checksum");
      applyStimulus(8'h02, 8'h8C, 8'h01, 8'h5F, 8'hEF, 1'b0, 40, -1, -1, 0, 0);
      checkOutput("badErr", error_code, 32'd2);
      checkOutput("badDataKept", data_out, 32'h028C015F);

      $display("[TB] no response");
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 0, -1, -1, 0, 0);
      checkOutput("noRespBusyWindow", (busyCycles >= 880 && busyCycles <= 888) ? 32'd1 : 32'd0, 32'd1);
      checkOutput("noRespErr", error_code, 32'd1);
      checkOutput("noRespOe", dht_oe, 32'd0);
      checkOutput("noRespDataKept", data_out, 32'h028C015F);

      $display("[TB] threshold boundary with ignored mid-frame start");
      applyStimulus(8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 1'b0, 40, 0, 15, 2000, 0);
      checkOutput("threshData", data_out, 32'h00010001);
      checkOutput("threshErr", error_code, 32'd0);

      $display("[TB] reset during bit 20");
      applyStimulus(8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 1'b0, 40, -1, -1, 0, 20);
      checkOutput("afterRstData", data_out, 32'd0);

      $display("[TB] fresh start after reset");
      applyStimulus(8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 40, -1, -1, 0, 0);
      checkOutput("freshData", data_out, 32'h01000000);
      checkOutput("freshErr", error_code, 32'd0);

      $display("[TB] truncated frame");
      applyStimulus(8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 1'b0, 39, -1, -1, 0, 0);
      checkOutput("truncErr", error_code, 32'd1);
      checkOutput("truncDataKept", data_out, 32'h01000000);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
